// File: rtl/text_pkg.sv
// Shared definitions for the text-mode console writer.
//   - Default screen geometry and blank-cell color.
//   - Counter and bus widths.
//   - ASCII control codes the writer interprets.
//   - Writer FSM state encoding.
package text_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;
    localparam logic [7:0] DEFAULT_BLANK_COLOR = 8'h07;

    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [7:0] ASCII_BS          = 8'h08;
    localparam logic [7:0] ASCII_LF          = 8'h0A;
    localparam logic [7:0] ASCII_FF          = 8'h0C;
    localparam logic [7:0] ASCII_CR          = 8'h0D;
    localparam logic [7:0] ASCII_SPACE       = 8'h20;
    localparam logic [7:0] ASCII_FIRST_PRINT = 8'h20;
    localparam logic [7:0] ASCII_LAST_PRINT  = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_SCROLL_RD = 3'd2,
        ST_SCROLL_WR = 3'd3,
        ST_CLEAR     = 3'd4
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_FIRST_PRINT) && (c <= ASCII_LAST_PRINT);
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream and text-RAM port B bundle for the console writer.
//   char_valid/char_data/char_color : producer -> writer
//   char_ready                       : writer -> producer
//   ram_addr/ram_wdata/ram_we        : writer -> RAM port B
//   ram_rdata                        : RAM port B -> writer (one cycle after ram_addr)
//
// Handshake: a character transfers on every rising clk edge where
// char_valid && char_ready are both high. The producer holds char_data and
// char_color stable while char_valid is high; char_ready never depends
// combinationally on char_valid.
interface text_console_writer_if;
    import text_pkg::*;

    logic              char_valid;
    logic [7:0]        char_data;
    logic [7:0]        char_color;
    logic              char_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // master: character producer plus the RAM model
    modport master (
        output char_valid, char_data, char_color, ram_rdata,
        input  char_ready, ram_addr, ram_wdata, ram_we
    );

    // slave: the console writer itself
    modport slave (
        input  char_valid, char_data, char_color, ram_rdata,
        output char_ready, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/text_cursor.sv
// Cursor counters for the console writer.
// Keeps (col, row) together with the linear cell offset row*COLS+col, all
// updated incrementally so no multiplier is needed.
//   clk, rst      : clock, asynchronous active-high reset
//   advance       : step one cell right, wrapping into a newline at the row end
//   back          : step one cell left (ignored at col 0)
//   cr            : return to col 0
//   lf            : col 0 and newline
//   home          : jump to (0,0)
//   col, row, off : current position and linear offset
//   at_col0       : col is 0
//   at_last_row   : row is ROWS-1
//   nl_on_advance : an advance now would wrap and request a newline
module text_cursor
    import text_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              back,
    input  logic              cr,
    input  logic              lf,
    input  logic              home,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] off,
    output logic              at_col0,
    output logic              at_last_row,
    output logic              nl_on_advance
);

    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COLS - 1);

    logic [ADDR_W-1:0] col_a;

    assign col_a         = ADDR_W'(col);
    assign at_col0       = (col == '0);
    assign at_last_row   = (row == LAST_ROW);
    assign nl_on_advance = (col == LAST_COL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            off <= '0;
        end else if (home) begin
            col <= '0;
            row <= '0;
            off <= '0;
        end else if (lf) begin
            // Back to the start of this line, then down one line unless
            // already on the last row (the scroll moves the text instead).
            col <= '0;
            if (at_last_row) begin
                off <= off - col_a;
            end else begin
                row <= row + 1'b1;
                off <= off - col_a + COLS_A;
            end
        end else if (cr) begin
            col <= '0;
            off <= off - col_a;
        end else if (back) begin
            if (!at_col0) begin
                col <= col - 1'b1;
                off <= off - 1'b1;
            end
        end else if (advance) begin
            if (nl_on_advance) begin
                col <= '0;
                if (at_last_row) begin
                    off <= off - LAST_COL_A;
                end else begin
                    // Start of next row is exactly one past the last column.
                    row <= row + 1'b1;
                    off <= off + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
                off <= off + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the text-mode display.
// Accepts ASCII characters, tracks a cursor and writes {color, ascii} cells
// into port B of the text RAM. Handles wrap, LF, CR, BS, FF and scrolling.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : character handshake and RAM port B (slave modport)
//   cursor_col  : current column 0..COLS-1
//   cursor_row  : current row 0..ROWS-1
//   busy        : FSM is anywhere but IDLE
//   dbg_state   : current FSM state
module text_console_writer
    import text_pkg::*;
#(
    parameter int          COLS           = DEFAULT_COLS,
    parameter int          ROWS           = DEFAULT_ROWS,
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter logic [7:0]  BLANK_COLOR    = DEFAULT_BLANK_COLOR,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    text_console_writer_if.slave bus,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy,
    output state_t            dbg_state
);

    localparam logic [DATA_W-1:0] BLANK_CELL = {BLANK_COLOR, ASCII_SPACE};
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COPY_CELLS = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = BASE_ADDR + ADDR_W'(COLS * ROWS - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              ready_q;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              scroll_pend_q, scroll_pend_d;

    logic              cur_adv, cur_back, cur_cr, cur_lf, cur_home;
    logic [ADDR_W-1:0] cur_off;
    logic              at_col0, at_last_row, nl_on_advance;
    logic              accept, is_print;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk           (clk),
        .rst           (rst),
        .advance       (cur_adv),
        .back          (cur_back),
        .cr            (cur_cr),
        .lf            (cur_lf),
        .home          (cur_home),
        .col           (cursor_col),
        .row           (cursor_row),
        .off           (cur_off),
        .at_col0       (at_col0),
        .at_last_row   (at_last_row),
        .nl_on_advance (nl_on_advance)
    );

    assign accept   = bus.char_valid && ready_q;
    assign is_print = is_printable(bus.char_data);

    assign bus.char_ready = ready_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_we     = we_q;
    // Scroll copy writes the word the RAM returns for the read issued in the
    // preceding SCROLL_RD cycle; it only exists during this cycle.
    assign bus.ram_wdata  = (state == ST_SCROLL_WR) ? bus.ram_rdata : wdata_q;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        state_d       = state;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = 1'b0;
        idx_d         = idx_q;
        scroll_pend_d = scroll_pend_q;
        cur_adv       = 1'b0;
        cur_back      = 1'b0;
        cur_cr        = 1'b0;
        cur_lf        = 1'b0;
        cur_home      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        cur_adv       = 1'b1;
                        we_d          = 1'b1;
                        addr_d        = BASE_ADDR + cur_off;
                        wdata_d       = {bus.char_color, bus.char_data};
                        scroll_pend_d = nl_on_advance && at_last_row;
                        state_d       = ST_WRITE;
                    end else begin
                        case (bus.char_data)
                            ASCII_BS: begin
                                if (!at_col0) begin
                                    cur_back      = 1'b1;
                                    we_d          = 1'b1;
                                    addr_d        = BASE_ADDR + cur_off - 16'd1;
                                    wdata_d       = BLANK_CELL;
                                    scroll_pend_d = 1'b0;
                                    state_d       = ST_WRITE;
                                end
                            end
                            ASCII_LF: begin
                                cur_lf = 1'b1;
                                if (at_last_row) begin
                                    addr_d  = BASE_ADDR + COLS_A;
                                    idx_d   = '0;
                                    state_d = ST_SCROLL_RD;
                                end
                            end
                            ASCII_CR: begin
                                cur_cr = 1'b1;
                            end
                            ASCII_FF: begin
                                cur_home = 1'b1;
                                we_d     = 1'b1;
                                addr_d   = BASE_ADDR;
                                wdata_d  = BLANK_CELL;
                                state_d  = ST_CLEAR;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            ST_WRITE: begin
                if (scroll_pend_q) begin
                    addr_d  = BASE_ADDR + COLS_A;
                    idx_d   = '0;
                    state_d = ST_SCROLL_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SCROLL_RD: begin
                we_d    = 1'b1;
                addr_d  = BASE_ADDR + idx_q;
                state_d = ST_SCROLL_WR;
            end

            ST_SCROLL_WR: begin
                if (idx_q == COPY_LAST) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + COPY_CELLS;
                    wdata_d = BLANK_CELL;
                    state_d = ST_CLEAR;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    addr_d  = BASE_ADDR + COLS_A + idx_q + 16'd1;
                    state_d = ST_SCROLL_RD;
                end
            end

            ST_CLEAR: begin
                // Every clear ends on the last cell of the screen. A clear
                // entered straight from reset has no write in flight yet, so
                // it first issues the write of the first cell.
                if (!we_q) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR;
                    wdata_d = BLANK_CELL;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            ready_q       <= 1'b0;
            idx_q         <= '0;
            scroll_pend_q <= 1'b0;
        end else begin
            state         <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            ready_q       <= (state_d == ST_IDLE);
            idx_q         <= idx_d;
            scroll_pend_q <= scroll_pend_d;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

    localparam int          COLS  = 80;
    localparam int          ROWS  = 30;
    localparam int          CELLS = COLS * ROWS;
    localparam logic [15:0] BLANK = 16'h0720;

    logic              clk;
    logic              rst;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              busy;
    text_pkg::state_t  dbg_state;

    text_console_writer_if bus ();

    text_console_writer #(
        .COLS           (COLS),
        .ROWS           (ROWS),
        .BASE_ADDR      (16'h0000),
        .BLANK_COLOR    (8'h07),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (synchronous read) ----------------
    logic [15:0] mem [0:4095];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < CELLS; k++) mem[k] <= 16'(k);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr[11:0]] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr[11:0]];
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every RAM write the DUT issues must be the next one the model predicted.
    always @(negedge clk) begin
        if (!rst && bus.ram_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, none expected (t=%0t)",
                         bus.ram_addr, bus.ram_wdata, $time);
            end else begin
                exp_w = exp_q.pop_front();
                check("ram_write", {bus.ram_addr, bus.ram_wdata}, exp_w);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] m_scr [0:CELLS-1];
    int          m_col, m_row;

    task automatic m_write(input int a, input logic [15:0] d);
        m_scr[a] = d;
        exp_q.push_back({16'(a), d});
    endtask

    task automatic m_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            for (int i = 0; i < COLS * (ROWS - 1); i++) m_write(i, m_scr[i + COLS]);
            for (int i = COLS * (ROWS - 1); i < CELLS; i++) m_write(i, BLANK);
        end
    endtask

    task automatic m_char(input logic [7:0] d, input logic [7:0] c);
        if (d >= 8'h20 && d <= 8'h7E) begin
            m_write(m_row * COLS + m_col, {c, d});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_newline();
            end
        end else if (d == 8'h0A) begin
            m_col = 0;
            m_newline();
        end else if (d == 8'h0D) begin
            m_col = 0;
        end else if (d == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_write(m_row * COLS + m_col, BLANK);
            end
        end else if (d == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) m_write(i, BLANK);
            m_col = 0;
            m_row = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // All driving happens 1 time unit after a rising edge.
    task automatic wait_idle();
        int g = 0;
        while (!(bus.char_ready && !busy) && g < 6000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 6000) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles", g);
        end
    endtask

    // Returns 1 time unit after the acceptance edge (cycle N+1).
    task automatic send_char(input logic [7:0] d, input logic [7:0] c);
        int g = 0;
        while (!bus.char_ready && g < 6000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 6000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: char_ready low for %0d cycles", g);
        end
        m_char(d, c);
        bus.char_valid = 1'b1;
        bus.char_data  = d;
        bus.char_color = c;
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name);
        check({name, "_col"}, 32'(cursor_col), 32'(m_col));
        check({name, "_row"}, 32'(cursor_row), 32'(m_row));
    endtask

    task automatic send_and_check(input logic [7:0] d, input logic [7:0] c);
        send_char(d, c);
        wait_idle();
        check_cursor("cursor");
    endtask

    // Holds reset (possibly asserted mid-operation), checks reset values,
    // then releases it and times the power-on clear.
    task automatic do_reset();
        int cnt;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_ram_we",    32'(bus.ram_we),     32'd0);
        check("rst_ram_addr",  32'(bus.ram_addr),   32'd0);
        check("rst_ram_wdata", 32'(bus.ram_wdata),  32'd0);
        check("rst_cur_col",   32'(cursor_col),     32'd0);
        check("rst_cur_row",   32'(cursor_row),     32'd0);
        check("rst_ready",     32'(bus.char_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        m_col = 0;
        m_row = 0;
        for (int i = 0; i < CELLS; i++) m_write(i, BLANK);
        rst = 1'b0;
        cnt = 0;
        @(posedge clk); #1;
        while (!bus.char_ready && cnt < 3000) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("reset_clear_ready_low_cycles", 32'(cnt), 32'd2400);
        check("reset_clear_writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          cnt;
        int          r;
        logic [7:0]  v;

        rst            = 1'b1;
        preload        = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.char_color = 8'h00;

        do_reset();
        check_cursor("after_reset");

        // Single printable: write issued in N+1, ready again in N+2.
        send_char(8'h41, 8'h1F);
        check("a_we",    32'(bus.ram_we),     32'd1);
        check("a_addr",  32'(bus.ram_addr),   32'd0);
        check("a_wdata", 32'(bus.ram_wdata),  32'h1F41);
        check("a_col_n1", 32'(cursor_col),    32'd1);
        check("a_ready_n1", 32'(bus.char_ready), 32'd0);
        @(posedge clk); #1;
        check("a_ready_n2", 32'(bus.char_ready), 32'd1);
        check_cursor("a_cursor");

        // Full line then 'Z' wraps onto row 1.
        send_and_check(8'h0D, 8'h00);
        for (int i = 0; i < COLS; i++) send_and_check(rand_print(), 8'($urandom));
        send_char(8'h5A, 8'h07);
        check("z_addr",  32'(bus.ram_addr),  32'd80);
        check("z_wdata", 32'(bus.ram_wdata), 32'h075A);
        wait_idle();
        check("z_col", 32'(cursor_col), 32'd1);
        check("z_row", 32'(cursor_row), 32'd1);

        // Backspace at (5,2) and at (0,3).
        send_and_check(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send_and_check(rand_print(), 8'($urandom));
        send_char(8'h08, 8'h00);
        check("bs_we",    32'(bus.ram_we),    32'd1);
        check("bs_addr",  32'(bus.ram_addr),  32'd164);
        check("bs_wdata", 32'(bus.ram_wdata), 32'h0720);
        check("bs_col",   32'(cursor_col),    32'd4);
        check("bs_row",   32'(cursor_row),    32'd2);
        wait_idle();
        send_and_check(8'h0A, 8'h00);
        send_char(8'h08, 8'h00);
        check("bs0_we",  32'(bus.ram_we), 32'd0);
        check("bs0_col", 32'(cursor_col), 32'd0);
        check("bs0_row", 32'(cursor_row), 32'd3);
        wait_idle();

        // Random mix of printables, CR, BS, LF and ignored codes.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                send_and_check(rand_print(), 8'($urandom));
            end else if (r < 86 || r >= 95) begin
                if (r < 86) begin
                    v = 8'h0D;
                end else begin
                    do v = 8'($urandom_range(0, 255));
                    while ((v >= 8'h20 && v <= 8'h7E) || v == 8'h08 || v == 8'h0A ||
                           v == 8'h0C || v == 8'h0D);
                end
                send_char(v, 8'($urandom));
                check("nowrite_ready_n1", 32'(bus.char_ready), 32'd1);
                check("nowrite_we_n1",    32'(bus.ram_we),     32'd0);
                check_cursor("nowrite_cursor_n1");
            end else if (r < 91) begin
                send_and_check(8'h08, 8'h00);
            end else if (m_row < 25) begin
                send_and_check(8'h0A, 8'h00);
            end
        end

        // Move to the last row, preload RAM with cell k = k, then LF scrolls.
        while (m_row < ROWS - 1) send_and_check(8'h0A, 8'h00);
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        for (int k = 0; k < CELLS; k++) m_scr[k] = 16'(k);
        send_char(8'h0A, 8'h00);
        cnt = 0;
        while (busy && cnt < 6000) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("scroll_busy_cycles", 32'(cnt), 32'd4720);
        wait_idle();
        check_cursor("scroll_cursor");
        check("scroll_mem0",    32'(mem[0]),    32'd80);
        check("scroll_mem2319", 32'(mem[2319]), 32'd2399);
        check("scroll_mem2320", 32'(mem[2320]), 32'h0720);
        check("scroll_mem2399", 32'(mem[2399]), 32'h0720);

        // A full last row wraps and scrolls from the WRITE state.
        for (int i = 0; i < COLS; i++) send_and_check(rand_print(), 8'($urandom));

        // Form feed clears everything and homes the cursor.
        send_and_check(8'h0C, 8'h00);
        check("ff_mem0", 32'(mem[0]), 32'h0720);

        // Reset 100 cycles into a scroll.
        while (m_row < ROWS - 1) send_and_check(8'h0A, 8'h00);
        send_char(8'h0A, 8'h00);
        repeat (99) @(posedge clk);
        #1;
        do_reset();
        wait_idle();
        check_cursor("after_rereset");
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream writer for the text-mode display. Accepts ASCII characters over a valid/ready handshake, tracks a cursor, and writes `{color, ascii}` cells into port B of the text-area RAM. The VGA controller reads the same cells from port A. Handles wrap, line feed, carriage return, backspace, form feed and hardware scroll. Port B arbitration against the core is done at top level and is out of scope here.

## Interface
- `COLS`, 80, characters per row.
- `ROWS`, 30, rows on screen.
- `BASE_ADDR`, 16'h0000, RAM word address of cell (0,0).
- `BLANK_COLOR`, 8'h07, color byte used for cleared and blanked cells.
- `CLEAR_ON_RESET`, 1, if 1, the whole screen is cleared after reset before accepting input.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `char_valid`  in  1  producer has a character.
- `char_data`  in  8  ASCII code.
- `char_color`  in  8  color byte, sampled with `char_data`.
- `char_ready`  out  1  block can accept a character this cycle.
- `ram_addr`  out  16  port B word address.
- `ram_wdata`  out  16  `{color[7:0], ascii[7:0]}`.
- `ram_we`  out  1  port B write strobe.
- `ram_rdata`  in  16  port B read data, valid one cycle after `ram_addr` (synchronous BRAM).
- `cursor_col`  out  7  current column, 0..COLS-1.
- `cursor_row`  out  5  current row, 0..ROWS-1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Transfer occurs on a cycle where `char_valid && char_ready`. `char_ready` is 1 only in IDLE.
- The cursor is held as (col, row) plus a linear offset `cur_off = row*COLS + col`, updated incrementally. No multiplier.
- Printable characters (0x20–0x7E):
  - Write `{char_color, char_data}` to `BASE_ADDR+cur_off`, then col++.
  - If col reaches COLS: col = 0, then perform newline.
- 0x0A (LF): col = 0, then newline.
- 0x0D (CR): col = 0. No RAM write.
- 0x08 (BS):
  - col > 0: col--, then write `{BLANK_COLOR, 8'h20}` at the new position.
  - col = 0: no-op, no write.
- 0x0C (FF): clear the whole screen, cursor set to (0,0).
- Any other code is consumed and ignored, with no write and no cursor change.
- Newline:
  - row < ROWS-1: row++.
  - row = ROWS-1: row is unchanged and a scroll runs.
- Scroll:
  - For i = 0..COLS*(ROWS-1)-1: SCROLL_RD presents `BASE_ADDR+i+COLS`; SCROLL_WR writes `ram_rdata` to `BASE_ADDR+i`.
  - Then CLEAR runs over the last row.
- CLEAR: writes `{BLANK_COLOR, 8'h20}`, one cell per cycle, over the requested range.
- States: IDLE, WRITE, SCROLL_RD, SCROLL_WR, CLEAR.
  - IDLE→WRITE on an accepted printable or BS-with-col>0.
  - IDLE→SCROLL_RD on LF or wrap at the last row.
  - IDLE→CLEAR on FF.
  - WRITE→IDLE, or WRITE→SCROLL_RD when the write caused a wrap at the last row.
  - SCROLL_RD↔SCROLL_WR alternate until the copy is done, then →CLEAR (last row).
  - CLEAR→IDLE after its last cell.

## Timing
- Reset values, asynchronous:
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, cursor (0,0), `char_ready`=0.
  - State is CLEAR over the full screen if `CLEAR_ON_RESET`, else IDLE.
  - In the IDLE case `char_ready`=1 on the first cycle after reset is released.
- Printable: accepted in cycle N; `ram_we`=1 in N+1 with the address and data registered; `char_ready`=1 again in N+2. Throughput is 1 character per 2 cycles.
- CR and ignored codes: block stays in IDLE; `char_ready` remains 1 the next cycle; cursor updates at N+1.
- Scroll: 2·COLS·(ROWS-1) cycles for the copy plus COLS cycles for the clear (4720 at defaults), then IDLE.
- Full clear: COLS·ROWS cycles (2400 at defaults).
- `ram_we` is asserted only in WRITE, SCROLL_WR and CLEAR. Outputs are registered.
- Cursor outputs update in the same cycle the write is issued. During a scroll they already show (0, ROWS-1).
- Reset asserted mid-scroll or mid-clear aborts immediately to reset values. The partial RAM contents are not repaired.

## Structure
- Package `text_pkg` holds:
  - `COLS`/`ROWS` defaults and `BLANK_COLOR`.
  - Control-code constants `ASCII_BS`, `ASCII_LF`, `ASCII_FF`, `ASCII_CR`.
  - The state enum.
- One sub-module, `text_cursor`: col/row/linear-offset counters with advance, back, CR and newline-request outputs. The FSM and RAM sequencing stay in `text_console_writer`.

## Test plan
- Reset, `CLEAR_ON_RESET`=1:
  - `char_ready`=0 for exactly 2400 cycles.
  - Addresses 0..2399 are each written 16'h0720 once, then `char_ready`=1.
- Send 'A' with color 0x1F at cursor (0,0): one write, addr 0, data 16'h1F41; cursor (1,0).
- Send 80 printables from (0,0), then 'Z' (color 0x07): the 81st write lands at addr 80 with data 16'h075A; cursor (1,1).
- BS at (5,2): one write, addr 164, data 16'h0720, cursor (4,2). BS at (0,3): no write, cursor unchanged.
- With the RAM model preloaded (cell k = k), LF at row 29:
  - Addr 0 receives 80 and addr 2319 receives 2399.
  - Addrs 2320..2399 receive 16'h0720.
  - Cursor (0,29); `busy` lasts 4720 cycles.
- Assert `rst` mid-scroll (cycle 100 of the scroll): next edge shows `ram_we`=0 and cursor (0,0); the block then re-clears as after reset.
